pe_feed_seq: RTL and testbench

- Host-side driver for the 8-input, 2-output hybrid processing element (PE).
- Accepts a serial word stream over a valid/ready handshake:
  - 8 state words
  - 8 norm-multiplier weights
  - 8 output weights
- Assembles the stream into the PE's wide DATA and WEIGHT buses, pulses the PE clock enable, waits out the PE's transfer-function latency, then presents the 64-bit PE result on a valid/ready output.
- Sits between the reservoir state/weight memory and one PE instance.

---
 rtl/pe_feed_pkg.sv | 23 ++
 rtl/pe_feed_lat_cnt.sv | 32 +++
 rtl/pe_feed_seq.sv | 160 ++++++++++++++++
 tb/tb_pe_feed_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feed_pkg.sv
// Shared types and default geometry for the PE feed sequencer.
package pe_feed_pkg;

  localparam int DEF_SWORD_LEN = 16;
  localparam int DEF_WWORD_LEN = 32;
  localparam int DEF_NEU_IN    = 8;
  localparam int DEF_PE_LAT    = 2;

  localparam int DATA_W   = DEF_SWORD_LEN * DEF_NEU_IN;
  localparam int WEIGHT_W = (DEF_SWORD_LEN + DEF_WWORD_LEN) * DEF_NEU_IN;
  localparam int Q_W      = 2 * DEF_WWORD_LEN;
  localparam int NW_OFS   = DEF_NEU_IN * DEF_SWORD_LEN;

  typedef enum logic [2:0] {
    LOAD_S  = 3'd0,
    LOAD_NW = 3'd1,
    LOAD_OW = 3'd2,
    FIRE    = 3'd3,
    WAIT    = 3'd4,
    OUT     = 3'd5
  } pe_state_t;

endpackage

// File: rtl/pe_feed_lat_cnt.sv
// Loadable down-counter that times the PE transfer-function latency.
module pe_feed_lat_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // done marks the last counted cycle, so the consumer acts on the edge ending it
  assign done_o = dec_i && (cnt_q == CW'(1));

endmodule

// File: rtl/pe_feed_seq.sv
// Serial-to-wide feed sequencer for one 8-in/2-out PE; optional weight retention
// is enabled by defining PE_FEED_WKEEP_EN.
module pe_feed_seq
  import pe_feed_pkg::*;
#(
  parameter int SWORD_LEN = DEF_SWORD_LEN,
  parameter int WWORD_LEN = DEF_WWORD_LEN,
  parameter int NEU_IN    = DEF_NEU_IN,
  parameter int PE_LAT    = DEF_PE_LAT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [WWORD_LEN-1:0]                    in_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_wkeep,
  output logic                                    pe_ce,
  output logic [SWORD_LEN*NEU_IN-1:0]             pe_data,
  output logic [(SWORD_LEN+WWORD_LEN)*NEU_IN-1:0] pe_weight,
  input  logic [2*WWORD_LEN-1:0]                  pe_q,
  output logic [2*WWORD_LEN-1:0]                  out_q,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    busy,
  output pe_state_t                               dbg_state
);

  localparam int DW  = SWORD_LEN * NEU_IN;
  localparam int WTW = (SWORD_LEN + WWORD_LEN) * NEU_IN;
  localparam int QW  = 2 * WWORD_LEN;
  localparam int NWO = NEU_IN * SWORD_LEN;
  localparam int BW  = (NEU_IN > 1) ? $clog2(NEU_IN) : 1;
  localparam int CW  = $clog2(PE_LAT + 1);

  // Handshakes: a word moves on a clk edge where in_valid && in_ready; a result
  // moves where out_valid && out_ready. Neither side buffers or flags stray strobes.

  pe_state_t      state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [DW-1:0]  data_q;
  logic [WTW-1:0] weight_q;
  logic [QW-1:0]  out_q_q;
  logic           out_valid_q;
  logic           accept, last_beat, skip_w, lat_load, lat_dec, lat_done, capture;
  int             s_ofs, w_ofs;

`ifdef PE_FEED_WKEEP_EN
  logic keep_q, keep_d;
  assign skip_w = (beat_q == '0) ? in_wkeep : keep_q;
`else
  logic unused_wkeep;
  assign unused_wkeep = in_wkeep;
  assign skip_w       = 1'b0;
`endif

  assign last_beat = (beat_q == BW'(NEU_IN - 1));
  assign s_ofs     = int'(beat_q) * SWORD_LEN;
  assign w_ofs     = NWO + int'(beat_q) * WWORD_LEN;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    in_ready = 1'b0;
    pe_ce    = 1'b0;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    capture  = 1'b0;
`ifdef PE_FEED_WKEEP_EN
    keep_d   = keep_q;
`endif
    case (state_q)
      LOAD_S, LOAD_NW, LOAD_OW: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_d = beat_q + BW'(1);
`ifdef PE_FEED_WKEEP_EN
          if (state_q == LOAD_S && beat_q == '0) keep_d = in_wkeep;
`endif
          if (last_beat) begin
            beat_d = '0;
            case (state_q)
              LOAD_S:  state_d = skip_w ? FIRE : LOAD_NW;
              LOAD_NW: state_d = LOAD_OW;
              default: state_d = FIRE;
            endcase
          end
        end
      end
      FIRE: begin
        pe_ce    = 1'b1;
        lat_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        lat_dec = 1'b1;
        if (lat_done) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = LOAD_S;
`ifdef PE_FEED_WKEEP_EN
          keep_d  = 1'b0;
`endif
        end
      end
      default: state_d = LOAD_S;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_S;
      beat_q      <= '0;
      data_q      <= '0;
      weight_q    <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef PE_FEED_WKEEP_EN
      keep_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
`ifdef PE_FEED_WKEEP_EN
      keep_q  <= keep_d;
`endif
      if (accept && state_q == LOAD_S)  data_q[s_ofs +: SWORD_LEN]   <= in_data[SWORD_LEN-1:0];
      if (accept && state_q == LOAD_NW) weight_q[s_ofs +: SWORD_LEN] <= in_data[SWORD_LEN-1:0];
      if (accept && state_q == LOAD_OW) weight_q[w_ofs +: WWORD_LEN] <= in_data;
      if (capture) begin
        out_q_q     <= pe_q;
        out_valid_q <= 1'b1;
      end else if (state_q == OUT && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  pe_feed_lat_cnt #(.CW(CW)) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (lat_load),
    .load_val_i (CW'(PE_LAT)),
    .dec_i      (lat_dec),
    .done_o     (lat_done)
  );

  assign pe_data   = data_q;
  assign pe_weight = weight_q;
  assign out_q     = out_q_q;
  assign out_valid = out_valid_q;
  assign busy      = !(state_q == LOAD_S && beat_q == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pe_feed_seq.sv
// Self-checking bench for pe_feed_seq against a frame-level model of the PE buses.
module tb_pe_feed_seq;

  localparam int SW  = 16;
  localparam int WW  = 32;
  localparam int N   = 8;
  localparam int LAT = 2;
  localparam int DW  = SW * N;
  localparam int WTW = (SW + WW) * N;
  localparam int QW  = 2 * WW;

  logic           clk, rst;
  logic [WW-1:0]  in_data;
  logic           in_valid, in_ready, in_wkeep;
  logic           pe_ce;
  logic [DW-1:0]  pe_data;
  logic [WTW-1:0] pe_weight;
  logic [QW-1:0]  pe_q, out_q;
  logic           out_valid, out_ready, busy;
  pe_feed_pkg::pe_state_t dbg_state;

  pe_feed_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wkeep  (in_wkeep),
    .pe_ce     (pe_ce),
    .pe_data   (pe_data),
    .pe_weight (pe_weight),
    .pe_q      (pe_q),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ce_cnt = 0;
  int ce_cyc[$];
  logic [QW-1:0] exp_q[$];

  logic [SW-1:0]  sw[N];
  logic [SW-1:0]  nw[N];
  logic [WW-1:0]  ow[N];
  logic [DW-1:0]  m_data;
  logic [WTW-1:0] m_weight;

  always @(posedge clk) cyc++;

  // scoreboard: every accepted result must match the oldest pending frame
  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (pe_ce) begin
      ce_cnt++;
      ce_cyc.push_back(cyc);
    end
    if (out_valid && out_ready && !rst) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected out_q=%h exp=none", out_q);
      end else begin
        e = exp_q.pop_front();
        if (out_q !== e) begin
          bad++;
          $display("FAIL sb_out_q got=%h exp=%h", out_q, e);
        end
      end
    end
  end

  // model: a full frame overwrites every state lane, and weights unless retained
  task automatic model_frame(input bit weights);
    for (int k = 0; k < N; k++) begin
      m_data[k*SW +: SW] = sw[k];
      if (weights) begin
        m_weight[k*SW +: SW]        = nw[k];
        m_weight[N*SW + k*WW +: WW] = ow[k];
      end
    end
  endtask

  task automatic randomize_frame();
    for (int k = 0; k < N; k++) begin
      sw[k] = SW'($urandom);
      nw[k] = SW'($urandom);
      ow[k] = $urandom;
    end
    pe_q = {$urandom, $urandom};
  endtask

  // driver
  task automatic send_beat(input logic [WW-1:0] w, input bit stall, input bit wk, output bit ok);
    int  n;
    bit  acc;
    if (stall) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    in_wkeep = wk;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_wkeep = 1'b0;
    ok = acc;
  endtask

  task automatic send_frame(input bit stall, input bit wk, input int first, input int last);
    logic [WW-1:0] w;
    bit ok;
    for (int i = first; i < last; i++) begin
      if (i < N)        w = {{(WW-SW){1'b0}}, sw[i]};
      else if (i < 2*N) w = {{(WW-SW){1'b0}}, nw[i-N]};
      else              w = ow[i-2*N];
      send_beat(w, stall, (i == 0) ? wk : 1'b0, ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL beat_timeout beat=%0d accepted=0 required=1", i);
        return;
      end
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_frame_result(input string tag, input int n, input int ce_before);
    total++;
    if (n !== LAT + 1) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", tag, n, LAT + 1); end
    total++;
    if (ce_cnt - ce_before !== 1) begin bad++; $display("FAIL %s_ce_pulses got=%0d exp=1", tag, ce_cnt - ce_before); end
    total++;
    if (pe_data !== m_data) begin bad++; $display("FAIL %s_pe_data got=%h exp=%h", tag, pe_data, m_data); end
    total++;
    if (pe_weight !== m_weight) begin bad++; $display("FAIL %s_pe_weight got=%h exp=%h", tag, pe_weight, m_weight); end
    total++;
    if (out_q !== pe_q) begin bad++; $display("FAIL %s_out_q got=%h exp=%h", tag, out_q, pe_q); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_wkeep = 1'b0; in_data = '0; out_ready = 1'b0; pe_q = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_data = '0; m_weight = '0;
    total++; if (pe_data !== '0)   begin bad++; $display("FAIL rst_pe_data got=%h exp=0", pe_data); end
    total++; if (pe_weight !== '0) begin bad++; $display("FAIL rst_pe_weight got=%h exp=0", pe_weight); end
    total++; if (out_q !== '0)     begin bad++; $display("FAIL rst_out_q got=%h exp=0", out_q); end
    total++; if ({pe_ce, out_valid, in_ready, busy} !== 4'b0010)
      begin bad++; $display("FAIL rst_ctrl got=%b exp=0010", {pe_ce, out_valid, in_ready, busy}); end
  endtask

  task automatic test_basic_frame();
    int n, ce0;
    logic [DW-1:0]  lanes;
    logic [WTW-1:0] wts;
    for (int k = 0; k < N; k++) begin
      sw[k] = SW'(k + 1);
      nw[k] = SW'(16 + k);
      ow[k] = 32'h0001_0000 + WW'(k);
    end
    pe_q = 64'h0123_4567_89AB_CDEF;
    ce0 = ce_cnt;
    send_frame(1'b0, 1'b0, 0, 3*N);
    model_frame(1'b1);
    exp_q.push_back(pe_q);
    total++; if (pe_ce !== 1'b1) begin bad++; $display("FAIL basic_ce_after_last got=%b exp=1", pe_ce); end
    wait_out(n);
    check_frame_result("basic", n, ce0);
    lanes = pe_data;
    wts   = pe_weight;
    total++; if (lanes[15:0] !== 16'h0001 || lanes[127:112] !== 16'h0008)
      begin bad++; $display("FAIL basic_lanes got=%h/%h exp=0001/0008", lanes[15:0], lanes[127:112]); end
    total++; if (wts[15:0] !== 16'h0010 || wts[159:128] !== 32'h0001_0000)
      begin bad++; $display("FAIL basic_weights got=%h/%h exp=0010/00010000", wts[15:0], wts[159:128]); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
  endtask

  task automatic test_backpressure();
    logic [QW-1:0] hold;
    int errs;
    hold = out_q;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_q !== hold || in_ready !== 1'b0) errs++;
    end
    in_valid = 1'b0;
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d exp=0", errs); end
    total++; if (pe_data !== m_data || pe_weight !== m_weight)
      begin bad++; $display("FAIL bp_ignored got=%h exp=%h", pe_data, m_data); end
    accept_out();
    total++; if ({out_valid, in_ready, busy} !== 3'b010)
      begin bad++; $display("FAIL bp_release got=%b exp=010", {out_valid, in_ready, busy}); end
  endtask

  task automatic test_random_stall();
    int n, ce0;
    for (int f = 0; f < 3; f++) begin
      randomize_frame();
      ce0 = ce_cnt;
      send_frame(1'b1, 1'b0, 0, 3*N);
      model_frame(1'b1);
      exp_q.push_back(pe_q);
      wait_out(n);
      check_frame_result("stall", n, ce0);
      accept_out();
    end
  endtask

  task automatic test_mid_reset();
    int n, ce0;
    randomize_frame();
    send_frame(1'b0, 1'b0, 0, 5);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_no_valid got=%b exp=0", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_data = '0; m_weight = '0;
    total++; if (pe_data !== m_data || pe_weight !== m_weight || {in_ready, busy} !== 2'b10)
      begin bad++; $display("FAIL mrst_cleared data=%h rdy_busy=%b exp=0/10", pe_data, {in_ready, busy}); end
    randomize_frame();
    ce0 = ce_cnt;
    send_frame(1'b0, 1'b0, 0, 3*N);
    model_frame(1'b1);
    exp_q.push_back(pe_q);
    wait_out(n);
    check_frame_result("mrst", n, ce0);
    accept_out();
  endtask

  task automatic test_wkeep();
    int n, ce0;
    randomize_frame();
    ce0 = ce_cnt;
    send_frame(1'b0, 1'b0, 0, 3*N);
    model_frame(1'b1);
    exp_q.push_back(pe_q);
    wait_out(n);
    check_frame_result("wk_full", n, ce0);
    accept_out();
    randomize_frame();
    ce0 = ce_cnt;
    send_frame(1'b0, 1'b1, 0, N);
`ifdef PE_FEED_WKEEP_EN
    total++; if (pe_ce !== 1'b1) begin bad++; $display("FAIL wk_ce_after_8 got=%b exp=1", pe_ce); end
    model_frame(1'b0);
`else
    total++; if ({pe_ce, in_ready, busy} !== 3'b011 || ce_cnt !== ce0)
      begin bad++; $display("FAIL wk_ignored got=%b exp=011", {pe_ce, in_ready, busy}); end
    send_frame(1'b0, 1'b0, N, 3*N);
    model_frame(1'b1);
`endif
    exp_q.push_back(pe_q);
    wait_out(n);
    check_frame_result("wk_keep", n, ce0);
    accept_out();
  endtask

  task automatic test_back_to_back();
    int n0, n;
    randomize_frame();
    out_ready = 1'b1;
    exp_q.push_back(pe_q);
    exp_q.push_back(pe_q);
    n0 = ce_cyc.size();
    send_frame(1'b0, 1'b0, 0, 3*N);
    send_frame(1'b0, 1'b0, 0, 3*N);
    model_frame(1'b1);
    wait_out(n);
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (ce_cyc.size() - n0 !== 2) begin
      bad++; $display("FAIL b2b_pulses got=%0d exp=2", ce_cyc.size() - n0);
    end else if (ce_cyc[n0+1] - ce_cyc[n0] !== 3*N + LAT + 2) begin
      bad++; $display("FAIL b2b_period got=%0d exp=%0d", ce_cyc[n0+1] - ce_cyc[n0], 3*N + LAT + 2);
    end
    total++; if (pe_data !== m_data || pe_weight !== m_weight)
      begin bad++; $display("FAIL b2b_buses got=%h exp=%h", pe_data, m_data); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_random_stall();
    test_mid_reset();
    test_wkeep();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
